// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encodings and default constants for pipe_ctrl
package pipe_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t RUN    = 2'd0;
  localparam state_t DRAIN  = 2'd1;
  localparam state_t HALTED = 2'd2;

  localparam int unsigned CNT_W             = 32;
  localparam int unsigned DEFAULT_INCREMENT = 4;
  localparam int unsigned DEFAULT_RESET_PC  = 0;

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - pipeline control bundle between controller and fetch datapath
interface pipe_ctrl_if #(
  parameter int unsigned width = 32
);
  import pipe_ctrl_pkg::*;

  logic             stall_c;
  logic             hazard_b;
  logic             redirect;
  logic [width-1:0] redirect_pc;
  logic             halt_req;

  logic [width-1:0] pc_a;
  logic             en_ab;
  logic             en_bc;
  logic             valid_b;
  logic             valid_c;
  logic             retire;
  logic             halted;
  logic [CNT_W-1:0] retired_count;
  logic [CNT_W-1:0] bubble_count;

  modport master (
    input  stall_c, hazard_b, redirect, redirect_pc, halt_req,
    output pc_a, en_ab, en_bc, valid_b, valid_c, retire, halted,
           retired_count, bubble_count
  );

  modport slave (
    output stall_c, hazard_b, redirect, redirect_pc, halt_req,
    input  pc_a, en_ab, en_bc, valid_b, valid_c, retire, halted,
           retired_count, bubble_count
  );

endinterface

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - wrapping event counter with enable and asynchronous reset
module perf_counter #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [width-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= count + width'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - PC owner and A/B/C stage sequencer with stall, hazard, redirect and halt handling
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned      width     = 32,
  parameter logic [width-1:0] increment = width'(DEFAULT_INCREMENT),
  parameter logic [width-1:0] reset_pc  = width'(DEFAULT_RESET_PC)
) (
  input logic         clk,
  input logic         reset,
  pipe_ctrl_if.master bus
);

  logic [width-1:0] pc_q;
  logic             valid_b_q;
  logic             valid_c_q;
  state_t           state_q;
  state_t           state_d;

  logic c_go;
  logic c_free;
  logic b_block;
  logic take_redirect;
  logic en_ab;
  logic en_bc;
  logic b_to_c;
  logic fetch_ok;
  logic [width-1:0] redirect_target;

  assign c_go          = valid_c_q & ~bus.stall_c;
  assign c_free        = ~valid_c_q | ~bus.stall_c;
  assign b_block       = valid_b_q & bus.hazard_b;
  assign take_redirect = bus.redirect & c_go;
  assign en_bc         = c_free;
  assign en_ab         = c_free & ~b_block;
  assign b_to_c        = valid_b_q & ~b_block & ~take_redirect;
  assign fetch_ok      = (state_q == RUN) & ~bus.halt_req;

  // Fetch addresses are word aligned; the low two target bits are dropped.
  assign redirect_target = bus.redirect_pc & ~width'(3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= reset_pc;
    end else if (take_redirect) begin
      pc_q <= redirect_target;
    end else if (en_ab & fetch_ok) begin
      pc_q <= pc_q + increment;
    end
  end

  // A redirect flushes both stages on its edge regardless of the enables.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_b_q <= 1'b0;
      valid_c_q <= 1'b0;
    end else if (take_redirect) begin
      valid_b_q <= 1'b0;
      valid_c_q <= 1'b0;
    end else begin
      if (en_ab) begin
        valid_b_q <= fetch_ok;
      end
      if (en_bc) begin
        valid_c_q <= b_to_c;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (bus.halt_req) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!bus.halt_req) begin
          state_d = RUN;
        end else if (!valid_b_q && !valid_c_q) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        if (!bus.halt_req) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  perf_counter #(.width(CNT_W)) u_retired_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (c_go),
    .count (bus.retired_count)
  );

  perf_counter #(.width(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (en_bc & ~b_to_c),
    .count (bus.bubble_count)
  );

  assign bus.pc_a    = pc_q;
  assign bus.en_ab   = en_ab;
  assign bus.en_bc   = en_bc;
  assign bus.valid_b = valid_b_q;
  assign bus.valid_c = valid_c_q;
  assign bus.retire  = c_go;
  assign bus.halted  = (state_q == HALTED);

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  pipe_ctrl_if #(.width(32)) bus ();

  pipe_ctrl #(.width(32), .increment(32'd4), .reset_pc(32'd0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    bus.stall_c     = 1'b0;
    bus.hazard_b    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.halt_req    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Clean run: cycle 0 begins right after reset release
    do_reset();
    #1;
    check("rst_pc",      bus.pc_a, 32'd0);
    check("rst_valid_b", bus.valid_b, 1'b0);
    check("rst_valid_c", bus.valid_c, 1'b0);
    check("rst_halted",  bus.halted, 1'b0);
    check("rst_en_ab",   bus.en_ab, 1'b1);
    check("rst_en_bc",   bus.en_bc, 1'b1);
    check("rst_retired", bus.retired_count, 32'd0);
    check("rst_bubble",  bus.bubble_count, 32'd0);
    for (int n = 0; n < 5; n++) begin
      check($sformatf("clean_pc%0d", n), bus.pc_a, 32'(4 * n));
      check($sformatf("clean_ret%0d", n), bus.retire, (n >= 2) ? 1'b1 : 1'b0);
      cyc();
      #1;
    end
    check("clean_retired_cnt", bus.retired_count, 32'd3);
    check("clean_bubble_cnt",  bus.bubble_count, 32'd1);

    // Stall with C holding PC 8; a concurrent redirect must be ignored
    do_reset();
    repeat (4) cyc();
    bus.stall_c     = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    #1;
    check("stall0_pc",     bus.pc_a, 32'd16);
    check("stall0_valid_c", bus.valid_c, 1'b1);
    check("stall0_en_ab",  bus.en_ab, 1'b0);
    check("stall0_en_bc",  bus.en_bc, 1'b0);
    check("stall0_retire", bus.retire, 1'b0);
    cyc();
    bus.redirect = 1'b0;
    #1;
    check("stall1_pc",      bus.pc_a, 32'd16);
    check("stall1_en_ab",   bus.en_ab, 1'b0);
    check("stall1_retired", bus.retired_count, 32'd2);
    check("stall1_bubble",  bus.bubble_count, 32'd1);
    cyc();
    bus.stall_c = 1'b0;
    #1;
    check("unstall_pc",     bus.pc_a, 32'd16);
    check("unstall_retire", bus.retire, 1'b1);

    // Hazard in B for one cycle (cycle 7)
    cyc();
    bus.hazard_b = 1'b1;
    #1;
    check("haz_pc",     bus.pc_a, 32'd20);
    check("haz_en_ab",  bus.en_ab, 1'b0);
    check("haz_en_bc",  bus.en_bc, 1'b1);
    check("haz_retire", bus.retire, 1'b1);
    cyc();
    bus.hazard_b = 1'b0;
    #1;
    check("haz_pc_hold", bus.pc_a, 32'd20);
    check("haz_valid_c", bus.valid_c, 1'b0);
    check("haz_valid_b", bus.valid_b, 1'b1);
    check("haz_bubble",  bus.bubble_count, 32'd2);

    // Redirect to 0x103 from C (cycle 9)
    cyc();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h103;
    #1;
    check("redir_valid_c", bus.valid_c, 1'b1);
    cyc();
    bus.redirect = 1'b0;
    #1;
    check("redir_pc",      bus.pc_a, 32'h100);
    check("redir_valid_b", bus.valid_b, 1'b0);
    check("redir_valid_c", bus.valid_c, 1'b0);
    cyc();
    #1;
    check("redir_pc_next", bus.pc_a, 32'h104);
    check("redir_no_ret",  bus.retire, 1'b0);
    cyc();
    #1;
    check("redir_retire",  bus.retire, 1'b1);
    check("redir_bubble",  bus.bubble_count, 32'd4);
    check("redir_retired", bus.retired_count, 32'd5);

    // Halt request held from cycle 12
    bus.halt_req = 1'b1;
    cyc();
    #1;
    check("drain_pc",      bus.pc_a, 32'h108);
    check("drain_halted",  bus.halted, 1'b0);
    check("drain_valid_b", bus.valid_b, 1'b0);
    check("drain_retire",  bus.retire, 1'b1);
    cyc();
    #1;
    check("drain_empty_halted", bus.halted, 1'b0);
    cyc();
    #1;
    check("halted_set", bus.halted, 1'b1);
    check("halted_pc",  bus.pc_a, 32'h108);
    cyc();
    bus.halt_req = 1'b0;
    #1;
    check("halted_pc2", bus.pc_a, 32'h108);
    cyc();
    #1;
    check("resume_halted",  bus.halted, 1'b0);
    check("resume_pc",      bus.pc_a, 32'h108);
    check("resume_valid_b", bus.valid_b, 1'b0);
    cyc();
    #1;
    check("resume_fetch_pc", bus.pc_a, 32'h10c);
    check("resume_fetch_vb", bus.valid_b, 1'b1);

    // Asynchronous reset during a stall with C valid
    cyc();
    bus.stall_c = 1'b1;
    #1;
    check("areset_pre_vc", bus.valid_c, 1'b1);
    reset = 1'b1;
    #1;
    check("areset_pc",      bus.pc_a, 32'd0);
    check("areset_valid_b", bus.valid_b, 1'b0);
    check("areset_valid_c", bus.valid_c, 1'b0);
    check("areset_en_ab",   bus.en_ab, 1'b1);
    check("areset_retire",  bus.retire, 1'b0);
    check("areset_retired", bus.retired_count, 32'd0);
    check("areset_bubble",  bus.bubble_count, 32'd0);
    cyc();
    reset       = 1'b0;
    bus.stall_c = 1'b0;
    #1;
    check("post_rst_pc", bus.pc_a, 32'd0);
    cyc();
    #1;
    check("post_rst_pc_next", bus.pc_a, 32'd4);
    check("post_rst_valid_b", bus.valid_b, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
